// File: rtl/sw_debouncer.sv
// sw_debouncer: conditions the raw slide-switch bus ahead of the cdd control
// block. Each bit is synchronised (2 flops), then debounced independently: the
// stable value only flips after DEBOUNCE_CYCLES consecutive synchronised
// mismatches. One-cycle strobes mark the edge on which data_out changes.
//
// Ports:
//   clock    - divided clock shared with cdd, rising edge
//   reset    - async active-low reset, clears all state
//   data_in  - raw asynchronous switch levels [WIDTH]
//   data_out - debounced stable value [WIDTH]
//   changed  - one-cycle pulse when data_out takes a new value
//   rise     - per-bit one-cycle pulse on 0->1 of data_out [WIDTH]
//   fall     - per-bit one-cycle pulse on 1->0 of data_out [WIDTH]

module sw_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CW              = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic flip
);
  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Last mismatch cycle of a full run: stable takes s2 on this edge.
  assign flip = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      // Strobes registered alongside stable so they line up with data_out.
      rise <= flip & s2;
      fall <= flip & ~s2;
      if (s2 == stable) begin
        cnt <= '0;           // any agreement discards the partial count
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module sw_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] flip;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sw_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .din   (data_in[i]),
      .stable(data_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .flip  (flip[i])
    );
  end

  // Single pulse even when several lanes flip together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) changed <= 1'b0;
    else        changed <= |flip;
  end
endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;
  localparam int W = 4;
  localparam int D = 4;

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         changed;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int           checks = 0;
  int           failures = 0;
  int           edge_n = 0;
  exp_t         sb[$];
  logic [W-1:0] model = '0;   // stimulus-side view of the settled value
  logic [W-1:0] cur_exp = '0; // monitor-side expected data_out

  sw_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .data_out(data_out),
    .changed (changed),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n++;

  // Value set just after negedge is steady before the next edge (E1);
  // the debounced update lands on E1+1+D.
  task automatic push_exp(input logic [W-1:0] nd, input logic [W-1:0] od);
    exp_t e;
    e.cyc = edge_n + 2 + D;
    e.d   = nd;
    e.r   = nd & ~od;
    e.f   = ~nd & od;
    sb.push_back(e);
  endtask

  task automatic apply(input logic [W-1:0] v);
    @(negedge clock);
    data_in = v;
    if (v != model) push_exp(v, model);
    model = v;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: timeout, %0d expected updates pending, want 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (data_out !== '0) begin failures++; $display("FAIL %s data_out: got %h want 0", name, data_out); end
    checks++;
    if (changed !== 1'b0) begin failures++; $display("FAIL %s changed: got %b want 0", name, changed); end
    checks++;
    if (rise !== '0) begin failures++; $display("FAIL %s rise: got %h want 0", name, rise); end
    checks++;
    if (fall !== '0) begin failures++; $display("FAIL %s fall: got %h want 0", name, fall); end
  endtask

  // Monitor: every cycle checks data_out against the expected stable value and
  // strobe/changed consistency; on changed it pops the scoreboard.
  always @(negedge clock) begin
    if (!reset) cur_exp = '0;
    if (changed === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_change: edge %0d data_out=%h rise=%h fall=%h", edge_n, data_out, rise, fall);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (edge_n != e.cyc) begin failures++; $display("FAIL change_edge: got edge %0d want %0d", edge_n, e.cyc); end
        checks++;
        if (data_out !== e.d) begin failures++; $display("FAIL change_data: got %h want %h", data_out, e.d); end
        checks++;
        if (rise !== e.r) begin failures++; $display("FAIL change_rise: got %h want %h", rise, e.r); end
        checks++;
        if (fall !== e.f) begin failures++; $display("FAIL change_fall: got %h want %h", fall, e.f); end
        cur_exp = e.d;
      end
    end
    checks++;
    if (data_out !== cur_exp) begin
      failures++;
      $display("FAIL data_track: edge %0d got %h want %h", edge_n, data_out, cur_exp);
    end
    checks++;
    if (((rise | fall) != '0) !== changed) begin
      failures++;
      $display("FAIL strobe_consistency: edge %0d changed=%b rise=%h fall=%h", edge_n, changed, rise, fall);
    end
  end

  initial begin
    data_in = 4'hF;
    reset   = 1'b1;
    #1 reset = 1'b0;
    #1 check_zero("reset_initial");

    // Release with all switches high: start-up rise on all bits.
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push_exp(4'hF, 4'h0);
    model = 4'hF;
    drain("reset_release");

    apply(4'h0);    drain("all_fall");
    apply(4'b0001); drain("clean_step_up");
    apply(4'b0000); drain("clean_step_down");

    // 3-cycle glitch on bit 2 never reaches the counter limit.
    @(negedge clock); data_in = 4'b0100;
    repeat (3) @(negedge clock);
    data_in = 4'b0000;
    repeat (12) @(negedge clock);

    // Bounce on bit 1 for 10 cycles, then settle high.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      data_in = (i % 2 == 0) ? 4'b0010 : 4'b0000;
    end
    apply(4'b0010); drain("bounce_settle");

    apply(4'b1010); drain("to_1010");
    apply(4'b0101); drain("simultaneous_flip");

    // Reset partway through a count: nothing counted survives.
    @(negedge clock); data_in = 4'b1000;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_zero("reset_midcount");
    model = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push_exp(4'b1000, 4'b0000);
    model = 4'b1000;
    drain("post_reset_rise");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
